// File: rtl/morse_player.sv
// morse_player
//
// Plays back a packed 10-bit morse word as a timed on/off signal, for example
// to drive an LED or buzzer. The word holds five 2-bit symbols, and the oldest
// symbol is in bits [9:8]. Symbols are played oldest first.
//
// Symbol codes:
//   01 = dot
//   11 = line
//   00 = none, skipped in one cycle
//   10 = none, skipped in one cycle
//
// A dot is a mark of DOT_CYCLES cycles. A line is a mark of 3*DOT_CYCLES
// cycles. Every mark is followed by a low space of DOT_CYCLES cycles. A
// one-cycle done pulse ends the playback.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous reset, active high, overrides everything
//   start       request playback of value; sampled only while idle
//   value       packed word, captured on the accepted start edge
//   signal_out  high during a mark
//   busy        high whenever a playback is in progress (any non-idle state)
//   done        one-cycle pulse after the final symbol and its space

module morse_player #(
    parameter int DOT_CYCLES = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] value,
    output logic       signal_out,
    output logic       busy,
    output logic       done
);

    // Wide enough to hold 3*DOT_CYCLES-1 (the line mark reload).
    localparam int CNT_W = $clog2(3 * DOT_CYCLES);
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LINE_LOAD = CNT_W'(3 * DOT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        MARK,
        SPACE,
        DONE
    } state_t;

    state_t           state_reg;
    logic [9:0]       sh_reg;
    logic [2:0]       n_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             signal_reg;
    logic             busy_reg;
    logic             done_reg;

    // The outputs are flops. Each one is written together with the state
    // transition that enters or leaves the corresponding state, so it always
    // matches the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            sh_reg     <= '0;
            n_reg      <= '0;
            cnt_reg    <= '0;
            signal_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sh_reg    <= value;
                        n_reg     <= 3'd5;
                        state_reg <= SCAN;
                        busy_reg  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (n_reg == 3'd0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        sh_reg <= {sh_reg[7:0], 2'b00};
                        n_reg  <= n_reg - 3'd1;
                        case (sh_reg[9:8])
                            2'b01: begin
                                state_reg  <= MARK;
                                cnt_reg    <= DOT_LOAD;
                                signal_reg <= 1'b1;
                            end
                            2'b11: begin
                                state_reg  <= MARK;
                                cnt_reg    <= LINE_LOAD;
                                signal_reg <= 1'b1;
                            end
                            // None codes: stay in SCAN, so the skipped pair
                            // costs exactly this one cycle.
                            default: ;
                        endcase
                    end
                end

                MARK: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= SPACE;
                        cnt_reg    <= DOT_LOAD;
                        signal_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                SPACE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= SCAN;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg  <= IDLE;
                    signal_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign signal_out = signal_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_morse_player.sv
// Testbench for morse_player.
//
// Two instances are used:
//   DOT_CYCLES = 1
//   DOT_CYCLES = 2
//
// Each table row starts one playback and records signal_out, busy and done
// for cycles 0..31. Cycle 0 is the cycle in which start is sampled. Bit c of
// each recorded vector holds the output value in cycle c, and the vectors are
// compared with the hand-computed values in the table. A hand-written sequence
// covers reset during a mark.

module tb_morse_player;

    logic       clock;
    logic       reset;
    logic       start_d1, start_d2;
    logic [9:0] value_d1, value_d2;
    logic       sig_d1, busy_d1, done_d1;
    logic       sig_d2, busy_d2, done_d2;

    int checks = 0;
    int errors = 0;

    morse_player #(.DOT_CYCLES(1)) dut_dot1 (
        .clock      (clock),
        .reset      (reset),
        .start      (start_d1),
        .value      (value_d1),
        .signal_out (sig_d1),
        .busy       (busy_d1),
        .done       (done_d1)
    );

    morse_player #(.DOT_CYCLES(2)) dut_dot2 (
        .clock      (clock),
        .reset      (reset),
        .start      (start_d2),
        .value      (value_d2),
        .signal_out (sig_d2),
        .busy       (busy_d2),
        .done       (done_d2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        dsel;          // 1: DOT_CYCLES=1 instance, 0: DOT_CYCLES=2
        logic [9:0]  value;
        int          start_len;     // start held high for cycles 0..start_len-1
        int          restart_cycle; // 0 = none, else extra start pulse in that cycle
        logic [9:0]  value2;        // value driven from restart_cycle onward
        logic [31:0] exp_sig;
        logic [31:0] exp_busy;
        logic [31:0] exp_done;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] sig, bsy, dn;
        logic        st;
        logic [9:0]  vl;
        sig = '0;
        bsy = '0;
        dn  = '0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clock);
            st = (c < v.start_len) || (v.restart_cycle != 0 && c == v.restart_cycle);
            vl = (v.restart_cycle != 0 && c >= v.restart_cycle) ? v.value2 : v.value;
            if (v.dsel) begin
                start_d1 = st;
                value_d1 = vl;
            end else begin
                start_d2 = st;
                value_d2 = vl;
            end
            #1;
            sig[c] = v.dsel ? sig_d1  : sig_d2;
            bsy[c] = v.dsel ? busy_d1 : busy_d2;
            dn[c]  = v.dsel ? done_d1 : done_d2;
        end
        start_d1 = 1'b0;
        start_d2 = 1'b0;
        check32({tag, " signal_out"}, sig, v.exp_sig);
        check32({tag, " busy"}, bsy, v.exp_busy);
        check32({tag, " done"}, dn, v.exp_done);
        check32({tag, " done_and_signal_overlap"}, sig & dn, 32'h0);
        $display("%s: dot=%0d value=%b sig=%h busy=%h done=%h",
                 tag, v.dsel ? 1 : 2, v.value, sig, bsy, dn);
    endtask

    initial begin
        vec_t        rv;
        logic [31:0] seen_busy, seen_done;

        // Dot then line.
        vecs[0] = '{1'b0, 10'b00_00_00_01_11, 1, 0, 10'b0,
                    32'h0000FC60, 32'h000FFFFE, 32'h00080000};
        // Empty word.
        vecs[1] = '{1'b0, 10'b00_00_00_00_00, 1, 0, 10'b0,
                    32'h00000000, 32'h000000FE, 32'h00000080};
        // Five lines.
        vecs[2] = '{1'b1, 10'b11_11_11_11_11, 1, 0, 10'b0,
                    32'h01CE739C, 32'h0FFFFFFE, 32'h08000000};
        // Interior and invalid skips.
        vecs[3] = '{1'b1, 10'b01_10_00_11_01, 1, 0, 10'b0,
                    32'h00001384, 32'h0000FFFE, 32'h00008000};
        // Interior and invalid skips at DOT_CYCLES=2.
        vecs[4] = '{1'b0, 10'b01_10_00_11_01, 1, 0, 10'b0,
                    32'h000C7E0C, 32'h00FFFFFE, 32'h00800000};
        // Single dot in the last pair.
        vecs[5] = '{1'b1, 10'b00_00_00_00_01, 1, 0, 10'b0,
                    32'h00000040, 32'h000003FE, 32'h00000200};
        // All invalid codes.
        vecs[6] = '{1'b1, 10'b10_10_10_10_10, 1, 0, 10'b0,
                    32'h00000000, 32'h000000FE, 32'h00000080};
        // Second start during MARK with a new value is ignored.
        vecs[7] = '{1'b0, 10'b00_00_00_01_11, 1, 6, 10'b11_11_11_11_11,
                    32'h0000FC60, 32'h000FFFFE, 32'h00080000};
        // Second start during SPACE with a new value is ignored.
        vecs[8] = '{1'b1, 10'b11_11_11_11_11, 1, 5, 10'b00_00_00_00_00,
                    32'h01CE739C, 32'h0FFFFFFE, 32'h08000000};
        // Start held high: restart in the IDLE cycle after each DONE.
        vecs[9] = '{1'b1, 10'b00_00_00_00_00, 32, 0, 10'b0,
                    32'h00000000, 32'hFEFEFEFE, 32'h80808080};

        reset    = 1'b1;
        start_d1 = 1'b0;
        start_d2 = 1'b0;
        value_d1 = '0;
        value_d2 = '0;
        repeat (3) @(negedge clock);
        check32("reset dot1 outputs", {29'b0, sig_d1, busy_d1, done_d1}, 32'h0);
        check32("reset dot2 outputs", {29'b0, sig_d2, busy_d2, done_d2}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check32("post-reset idle dot1", {29'b0, sig_d1, busy_d1, done_d1}, 32'h0);
        check32("post-reset idle dot2", {29'b0, sig_d2, busy_d2, done_d2}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during the second cycle of a line (DOT_CYCLES=2).
        // Cycle 1 is SCAN, and the line mark runs in cycles 2-7.
        @(negedge clock);
        start_d2 = 1'b1;
        value_d2 = 10'b11_00_00_00_00;   // cycle 0
        @(negedge clock);
        start_d2 = 1'b0;                 // cycle 1 (SCAN)
        @(negedge clock);                // cycle 2 (MARK)
        @(negedge clock);                // cycle 3 (MARK, second cycle)
        #1;
        check32("reset_seq mark before reset", {31'b0, sig_d2}, 32'h1);
        reset = 1'b1;
        @(negedge clock);                // cycle 4
        #1;
        check32("reset_seq outputs after reset", {29'b0, sig_d2, busy_d2, done_d2}, 32'h0);
        reset = 1'b0;
        seen_busy = '0;
        seen_done = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            #1;
            seen_busy[c] = busy_d2;
            seen_done[c] = done_d2 | sig_d2;
        end
        check32("reset_seq stays idle busy", seen_busy, 32'h0);
        check32("reset_seq no done or mark", seen_done, 32'h0);
        $display("reset_seq: line aborted at cycle 3, outputs cleared");

        // The new word plays from its first symbol. The dot mark is in
        // cycles 2-3, and done is in cycle 11.
        rv = '{1'b0, 10'b01_00_00_00_00, 1, 0, 10'b0,
               32'h0000000C, 32'h00000FFE, 32'h00000800};
        run_vec(rv, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_player.md
# morse_player

Transmit-side counterpart to the player morse input path. Accepts a packed 10-bit morse word and replays it as a timed on/off signal on `signal_out`, for example to drive an LED or buzzer so the opposing player can read the code. The word format matches the player registers: five 2-bit symbols, with the oldest symbol in the most significant pair. Playback is oldest symbol first, and the block raises a one-cycle `done` pulse when it finishes.

## Interface
- `DOT_CYCLES`, default 25_000_000: length of one dot mark, one line unit and one inter-symbol gap, in clock cycles. Must be ≥ 1.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  request playback of `value`; sampled only in IDLE.
- `value`  in  10  packed word, symbol k in bits [9-2k:8-2k]. Codes: 01 = dot, 11 = line, 00 = none, 10 = none.
- `signal_out`  out  1  high during a mark, low otherwise.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.

## Operation
- States are IDLE, SCAN, MARK, SPACE and DONE. All outputs are decoded from registered state.
- Registers:
  - 10-bit shift register `sh`.
  - 3-bit pair counter `n`.
  - Duration counter `cnt`, wide enough for 3*DOT_CYCLES-1.
- IDLE
  - If `start`=1: load `sh`←`value` and `n`←5, then go to SCAN.
  - Otherwise stay in IDLE.
- SCAN
  - If `n`=0, go to DONE.
  - Otherwise inspect `sh[9:8]`, then shift `sh`←{`sh[7:0]`,2'b00} and decrement `n`.
  - Code 01: go to MARK with `cnt`←DOT_CYCLES-1.
  - Code 11: go to MARK with `cnt`←3*DOT_CYCLES-1.
  - Code 00 or 10: stay in SCAN. A skipped pair costs exactly one cycle.
- MARK
  - `signal_out`=1.
  - If `cnt`=0, go to SPACE with `cnt`←DOT_CYCLES-1. Otherwise decrement `cnt`.
- SPACE
  - `signal_out`=0.
  - If `cnt`=0, go to SCAN. Otherwise decrement `cnt`.
- DONE
  - `done`=1 for this single cycle, then go to IDLE.
- `start` is ignored in every state except IDLE. `value` is captured only at the start edge, so later changes to `value` have no effect.
- Invalid code 10 is treated as none: it is skipped and produces no mark.
- Skipping happens wherever a none pair sits, leading or interior.

## Timing
- Reset forces:
  - state=IDLE
  - `signal_out`=0, `busy`=0, `done`=0
  - `sh`=0, `n`=0, `cnt`=0
- Reset has priority over every other input and aborts playback mid-mark. `signal_out` is low on the cycle after the reset edge.
- Counting from the cycle in which `start` is sampled (cycle 0):
  - `busy` rises at cycle 1.
  - The first SCAN occurs at cycle 1.
- Durations:
  - Mark: DOT_CYCLES cycles for a dot, 3*DOT_CYCLES for a line.
  - A SPACE of DOT_CYCLES cycles follows every mark, including the last one.
  - Each SCAN visit costs 1 cycle: 5 pair visits plus one final visit with `n`=0.
- Total busy cycles = 6 + Σ(mark+space) + 1 (DONE).
- `busy` falls in the cycle after DONE. A `start` held high in that IDLE cycle begins a new playback immediately, with no lost cycle.
- `done` and `signal_out` are never high in the same cycle.

## Test plan
- Dot then line. DOT_CYCLES=2, `value`=10'b00_00_00_01_11, `start` pulsed at cycle 0.
  - SCAN at cycles 1-4.
  - `signal_out` high cycles 5-6, low 7-9, high 10-15, low 16-18.
  - `done` at 19, `busy` high cycles 1-19.
- Empty word. `value`=0.
  - `signal_out` never high.
  - `done` at cycle 7, `busy` high cycles 1-7.
- Five lines. DOT_CYCLES=1, `value`=10'b11_11_11_11_11.
  - Exactly 5 marks of 3 cycles each, separated by 1 low SPACE cycle plus 1 SCAN cycle.
  - `done` at cycle 27.
- Interior/invalid skip. `value`=10'b01_10_00_11_01.
  - Sequence is dot, line, dot.
  - Code 10 and code 00 each cost 1 cycle and produce no mark.
- Start while busy.
  - A second `start` with a different `value` during MARK is ignored and the original sequence completes unchanged.
  - `start` held high through DONE restarts playback at the IDLE cycle.
- Reset mid-mark. Assert `reset` during the second cycle of a line.
  - Next cycle: `signal_out`=0, `busy`=0, no `done` pulse.
  - A subsequent `start` plays the new word from its first symbol.
